dcache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the CPU memory stage and `datamem`. Loads that hit return extended data combinationally in the same cycle. Load misses stall the pipeline while a 4-word line is refilled from `datamem`, one word per cycle. Stores always write through to `datamem` in the same cycle and never stall.

---
 rtl/dcache_pkg.sv | 56 +++++
 rtl/dcache_load_extend.sv | 27 ++
 rtl/dcache.sv | 145 ++++++++++++++
 tb/tb_dcache.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
// Holds access-width codes, FSM states, address-field sizing and store byte-merge.
package dcache_pkg;

  typedef enum logic [2:0] {
    W_WORD  = 3'b000,
    W_HALF  = 3'b001,
    W_BYTE  = 3'b010,
    W_BYTEU = 3'b100,
    W_HALFU = 3'b101
  } width_t;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_REFILL = 1'b1
  } state_t;

  localparam int WORD_BYTES = 4;

  function automatic int offset_bits(input int line_words);
    return $clog2(line_words * WORD_BYTES);
  endfunction

  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] width, input logic [1:0] lane);
    case (width)
      W_BYTE, W_BYTEU: lane_mask = 4'b0001 << lane;
      W_HALF, W_HALFU: lane_mask = lane[1] ? 4'b1100 : 4'b0011;
      default:         lane_mask = 4'b1111;
    endcase
  endfunction

  // Store data arrives right-aligned; replicate it so every enabled lane sees its bytes.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [2:0] width, input logic [1:0] lane);
    logic [31:0] rep;
    logic [3:0]  mask;
    case (width)
      W_BYTE, W_BYTEU: rep = {4{wdata[7:0]}};
      W_HALF, W_HALFU: rep = {2{wdata[15:0]}};
      default:         rep = wdata;
    endcase
    mask = lane_mask(width, lane);
    for (int i = 0; i < 4; i++) begin
      store_merge[8*i +: 8] = mask[i] ? rep[8*i +: 8] : old[8*i +: 8];
    end
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/dcache_load_extend.sv
// Selects the byte/half lane of a 32-bit word and sign- or zero-extends it.
// Purely combinational so it can also sit on an uncached load path.
module load_extend
  import dcache_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  width,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{lane, 3'b000} +: 8];
    half_v = lane[1] ? word[31:16] : word[15:0];
    case (width)
      W_HALF:  result = {{16{half_v[15]}}, half_v};
      W_HALFU: result = {16'h0000, half_v};
      W_BYTE:  result = {{24{byte_v[7]}}, byte_v};
      W_BYTEU: result = {24'h000000, byte_v};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache in front of datamem.
// Load hits answer in the request cycle; misses refill a 4-word line over 4 stalled cycles.
module dcache
  import dcache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wen,
  input  logic        ren,
  input  logic [2:0]  DataWidth,
  output logic [31:0] dout,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic [2:0]  mem_DataWidth,
  input  logic [31:0] mem_dout,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int OFF_W = offset_bits(LINE_WORDS);
  localparam int IDX_W = index_bits(SETS);
  localparam int TAG_W = 32 - IDX_W - OFF_W;

  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic [1:0]       wsel;
  logic [1:0]       lane;

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS][LINE_WORDS];

  state_t      state;
  logic [1:0]  cnt;
  logic        replay;
  logic        hit;
  logic [31:0] cached_word;
  logic [31:0] ext_word;

  assign index       = addr[OFF_W +: IDX_W];
  assign tag         = addr[31 -: TAG_W];
  assign wsel        = addr[3:2];
  assign lane        = addr[1:0];
  assign hit         = valid[index] && (tags[index] == tag);
  assign cached_word = data[index][wsel];

  load_extend u_extend (
    .word   (cached_word),
    .lane   (lane),
    .width  (DataWidth),
    .result (ext_word)
  );

  // Request decode: hit data, miss/refill addressing and store pass-through; all quiet in reset.
  always_comb begin
    stall         = 1'b0;
    dout          = 32'h0000_0000;
    mem_addr      = 32'h0000_0000;
    mem_wdata     = 32'h0000_0000;
    mem_wen       = 1'b0;
    mem_DataWidth = W_WORD;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          dout = ext_word;
          if (ren && !hit) begin
            stall    = 1'b1;
            mem_addr = {addr[31:OFF_W], {OFF_W{1'b0}}};
          end else if (wen) begin
            mem_addr      = addr;
            mem_wdata     = wdata;
            mem_wen       = 1'b1;
            mem_DataWidth = DataWidth;
          end else begin
            stall = 1'b0;
          end
        end
        S_REFILL: begin
          stall    = 1'b1;
          mem_addr = {addr[31:OFF_W], cnt, 2'b00};
        end
        default: stall = 1'b0;
      endcase
    end else begin
      stall = 1'b0;
    end
  end

  // Line state, refill sequencing and hit/miss counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 2'd0;
      valid      <= '0;
      hit_count  <= 32'h0000_0000;
      miss_count <= 32'h0000_0000;
      replay     <= 1'b0;
    end else begin
      replay <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ren && !hit) begin
            // The old line is invalidated up front so a half-filled set is never seen as a hit.
            valid[index]   <= 1'b0;
            data[index][0] <= mem_dout;
            cnt            <= 2'd1;
            miss_count     <= sat_inc(miss_count);
            state          <= S_REFILL;
          end else if (ren) begin
            if (!replay) begin
              hit_count <= sat_inc(hit_count);
            end else begin
              hit_count <= hit_count;
            end
          end else if (wen && hit) begin
            data[index][wsel] <= store_merge(cached_word, wdata, DataWidth, lane);
          end else begin
            state <= S_IDLE;
          end
        end
        S_REFILL: begin
          data[index][cnt] <= mem_dout;
          if (cnt == 2'd3) begin
            tags[index]  <= tag;
            valid[index] <= 1'b1;
            cnt          <= 2'd0;
            replay       <= 1'b1;
            state        <= S_IDLE;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed table, hand sequences and random traffic
// compared against a line-residency model plus a reference copy of memory.
module tb_dcache;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wen;
  logic        ren;
  logic [2:0]  DataWidth;
  logic [31:0] dout;
  logic        stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic [2:0]  mem_DataWidth;
  logic [31:0] mem_dout;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;

  dcache #(.SETS(64), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wen(wen), .ren(ren),
    .DataWidth(DataWidth), .dout(dout), .stall(stall), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_DataWidth(mem_DataWidth),
    .mem_dout(mem_dout), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [15:0] i);
    case (i)
      16'h4000: return 32'h1122_3344;
      16'h4001: return 32'h99AA_BBCC;
      16'h4002: return 32'hDDEE_FF00;
      16'h4003: return 32'h5566_7788;
      default:  return ({16'h0, i} * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] d,
                                              input logic [2:0] w, input logic [1:0] a);
    int nbytes;
    int first;
    logic [31:0] res;
    nbytes = (w == 3'b010 || w == 3'b100) ? 1 : (w == 3'b001 || w == 3'b101) ? 2 : 4;
    first  = (nbytes == 4) ? 0 : (nbytes == 2) ? (a[1] ? 2 : 0) : int'(a);
    res = old;
    for (int k = 0; k < nbytes; k++) res[8*(first+k) +: 8] = d[8*k +: 8];
    return res;
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] a, input logic [2:0] t);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * int'(a))) & 32'h0000_00FF;
    h = (w >> (16 * int'(a[1]))) & 32'h0000_FFFF;
    case (t)
      3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
      3'b101:  return h;
      3'b010:  return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'b100:  return b;
      default: return w;
    endcase
  endfunction

  // datamem: initial image XOR a delta that only the DUT's write port changes
  logic [31:0] delta [0:65535] = '{default: 32'h0};
  assign mem_dout = init_word(mem_addr[17:2]) ^ delta[mem_addr[17:2]];

  always @(posedge clk) begin
    if (mem_wen)
      delta[mem_addr[17:2]] <= merge_bytes(mem_dout, mem_wdata, mem_DataWidth, mem_addr[1:0])
                               ^ init_word(mem_addr[17:2]);
  end

  // reference model
  logic [31:0] ref_mem [0:65535];
  int          resident [int];
  int          exp_hits;
  int          exp_misses;
  logic [31:0] maddr_q [$];

  typedef struct {
    logic [31:0] a;
    logic [2:0]  w;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] w, output logic [31:0] d, output int stalls);
    addr = a; DataWidth = w; ren = 1'b1; wen = 1'b0; stalls = 0;
    maddr_q.delete();
    @(negedge clk);
    while (stall && stalls < 20) begin
      maddr_q.push_back(mem_addr);
      stalls++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    d = dout;
    @(posedge clk); #1;
    ren = 1'b0;
  endtask

  task automatic model_load(input logic [31:0] a, input logic [2:0] w, input string name,
                            output logic [31:0] d);
    int idx;
    int line;
    bit hit_e;
    int st;
    idx   = int'(a[9:4]);
    line  = int'(a & 32'hFFFF_FFF0);
    hit_e = resident.exists(idx) && resident[idx] == line;
    load(a, w, d, st);
    check({name, " stall_cycles"}, st, hit_e ? 32'd0 : 32'd4);
    check({name, " dout"}, d, ext(ref_mem[a[17:2]], a[1:0], w));
    if (hit_e) exp_hits++;
    else begin
      exp_misses++;
      resident[idx] = line;
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] w, input string name);
    addr = a; wdata = d; DataWidth = w; wen = 1'b1; ren = 1'b0;
    @(negedge clk);
    check({name, " stall/mem_wen/width"}, {27'h0, stall, mem_wen, mem_DataWidth}, {27'h0, 1'b0, 1'b1, w});
    check({name, " mem_addr"}, mem_addr, a);
    check({name, " mem_wdata"}, mem_wdata, d);
    @(posedge clk); #1;
    wen = 1'b0;
    ref_mem[a[17:2]] = merge_bytes(ref_mem[a[17:2]], d, w, a[1:0]);
  endtask

  task automatic check_counters(input string name);
    check({name, " hit_count"}, hit_count, exp_hits);
    check({name, " miss_count"}, miss_count, exp_misses);
  endtask

  logic [31:0] d;
  logic [31:0] bases [6];
  logic [2:0]  widths [8];

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i[15:0]);
    vecs[0] = '{32'h0001_0000, 3'b000, 32'h1122_3344};
    vecs[1] = '{32'h0001_000E, 3'b001, 32'h0000_5566};
    vecs[2] = '{32'h0001_000F, 3'b100, 32'h0000_0055};
    vecs[3] = '{32'h0001_0004, 3'b010, 32'hFFFF_FFCC};
    vecs[4] = '{32'h0001_0006, 3'b101, 32'h0000_99AA};
    vecs[5] = '{32'h0001_0006, 3'b001, 32'hFFFF_99AA};
    vecs[6] = '{32'h0001_000B, 3'b010, 32'hFFFF_FFDD};
    vecs[7] = '{32'h0001_000D, 3'b111, 32'h5566_7788};
    vecs[8] = '{32'h0001_0009, 3'b001, 32'hFFFF_FF00};
    vecs[9] = '{32'h0001_000A, 3'b100, 32'h0000_00EE};
    bases  = '{32'h0001_0000, 32'h0001_0400, 32'h0002_0000, 32'h0002_0400, 32'h0001_0010, 32'h0003_0020};
    widths = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    exp_hits = 0; exp_misses = 0;

    // reset with a pending load that would otherwise miss
    rst = 1'b1; ren = 1'b1; wen = 1'b0; addr = 32'h0001_0000; wdata = 32'h0; DataWidth = 3'b000;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset stall/mem_wen", {30'h0, stall, mem_wen}, 32'h0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_wdata/width", mem_wdata | {29'h0, mem_DataWidth}, 32'h0);
    check("reset dout", dout, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; ren = 1'b0;
    check_counters("after reset");
    @(negedge clk);
    check("idle stall/mem_wen", {30'h0, stall, mem_wen}, 32'h0);
    @(posedge clk); #1;

    // first miss: refill address sequence and 5th-cycle data
    model_load(32'h0001_0000, 3'b000, "first_miss", d);
    check("first_miss refill addr count", maddr_q.size(), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < maddr_q.size()) check("first_miss refill addr", maddr_q[k], 32'h0001_0000 + 32'(4 * k));
    check_counters("first_miss");

    // table of hits on the resident line
    for (int i = 0; i < 10; i++) begin
      int st;
      load(vecs[i].a, vecs[i].w, d, st);
      check("table stall_cycles", st, 32'd0);
      check("table dout", d, vecs[i].exp);
      exp_hits++;
    end
    check_counters("table");

    // store hit merges into the cached line
    store(32'h0001_0001, 32'h0000_00AB, 3'b010, "store_hit");
    model_load(32'h0001_0000, 3'b000, "load_after_store", d);
    check("load_after_store merged", d, 32'h1122_AB44);

    // store miss writes memory only
    store(32'h0002_0000, 32'hDEAD_BEEF, 3'b000, "store_miss");
    check("store_miss datamem", mem_dout === 32'hx ? 32'h0 : (init_word(16'h8000) ^ delta[16'h8000]), 32'hDEAD_BEEF);
    model_load(32'h0002_0000, 3'b000, "load_after_store_miss", d);
    check("load_after_store_miss value", d, 32'hDEAD_BEEF);

    // conflicting tags in one set
    model_load(32'h0001_0400, 3'b000, "conflict_a", d);
    model_load(32'h0001_0000, 3'b000, "conflict_b", d);
    check_counters("conflict");

    // reset in the 2nd refill cycle
    addr = 32'h0003_0040; DataWidth = 3'b000; ren = 1'b1;
    @(negedge clk);
    check("midreset miss stall", {31'h0, stall}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midreset stall/mem_wen", {30'h0, stall, mem_wen}, 32'h0);
    check("midreset mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; ren = 1'b0;
    resident.delete(); exp_hits = 0; exp_misses = 0;
    check_counters("midreset");
    model_load(32'h0003_0040, 3'b000, "midreset_reissue", d);
    check_counters("midreset_reissue");

    // random traffic
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [2:0]  w;
      a = bases[$urandom_range(0, 5)] + 32'($urandom_range(0, 15));
      w = widths[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) < 6) model_load(a, w, "rand_load", d);
      else store(a, $urandom, w, "rand_store");
    end
    check_counters("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
